// File: rtl/serial_xfer_ctrl_pkg.sv
// Shared definitions for the serial transfer controller: FSM state encoding
// and the default word width.
package serial_xfer_ctrl_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_xfer_ctrl_shift_left_reg.sv
// Left-shifting register with parallel load; serial input enters at bit 0
// so the MSB leaves first.
module shift_left_reg
  import serial_xfer_ctrl_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         load_i,
  input  logic         shift_en_i,
  input  logic         sin_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (shift_en_i) begin
      q_d = {q_q[N-2:0], sin_i};
    end else begin
      q_d = q_q;
    end
  end

  // Register state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_xfer_ctrl.sv
// Serial transfer controller: loads a parallel word, shifts it out MSB first
// while shifting sin in, then presents the received word with valid/ready.
module serial_xfer_ctrl
  import serial_xfer_ctrl_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] Data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sin,
  output logic         sout,
  output logic         sout_en,
  output logic [N-1:0] RxData,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         abort
);

  localparam int CW = $clog2(N + 1);

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         load_s;
  logic         shift_s;
  logic [N-1:0] q_s;

  // Next-state, counter and shift-register control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          load_s  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // An aborted cycle does not shift, so Q keeps its partial contents.
        if (abort) begin
          state_d = IDLE;
        end else begin
          shift_s = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bit-counter registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_left_reg #(.N(N)) u_shift_reg (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .load_i     (load_s),
    .shift_en_i (shift_s),
    .sin_i      (sin),
    .d_i        (Data),
    .q_o        (q_s)
  );

  assign in_ready  = (state_q == IDLE);
  assign sout_en   = (state_q == SHIFT);
  assign sout      = sout_en & q_s[N-1];
  assign out_valid = (state_q == DONE);
  assign RxData    = q_s;

endmodule

// File: doc/serial_xfer_ctrl.md
SERIAL_XFER_CTRL -- requirements
Module: serial_xfer_ctrl

Interface
REQ-001 Parameter: N, default 8, word width in bits (N >= 2).
REQ-002 Clock  input  1  rising-edge clock.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Data  input  N  parallel word to transmit.
REQ-005 in_valid  input  1  Data is valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 sin  input  1  serial receive bit, sampled each shift cycle.
REQ-008 sout  output  1  serial transmit bit, MSB first.
REQ-009 sout_en  output  1  sout and the sin sample are meaningful this cycle.
REQ-010 RxData  output  N  received word.
REQ-011 out_valid  output  1  RxData is valid.
REQ-012 out_ready  input  1  consumer accepts RxData.
REQ-013 abort  input  1  synchronous cancel of the transfer in progress.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 IDLE: in_ready=1; accept = in_valid & in_ready & ~abort.
- On accept, load Data into the internal shift register, clear bit counter, go to SHIFT.
REQ-016 SHIFT: sout = Q[N-1], sout_en=1, in_ready=0.
- Each edge: Q <= {Q[N-2:0], sin}; counter increments.
REQ-017 After the N-th shift edge, the FSM SHALL enter DONE; SHIFT lasts exactly N cycles.
REQ-018 Latency: the first bit SHALL appear on sout in the cycle after accept; out_valid SHALL rise N+1 cycles after accept.
REQ-019 DONE: out_valid=1, RxData=Q held stable, no shifting.
- out_valid & out_ready -> IDLE on the next edge.
REQ-020 in_valid while not in IDLE SHALL be ignored; Data is not captured.
REQ-021 abort in SHIFT or DONE SHALL force IDLE on the next edge with no out_valid pulse; Q keeps its value.
REQ-022 abort and in_valid together in IDLE: abort wins, nothing is loaded.
REQ-023 The counter SHALL be $clog2(N+1) bits wide and SHALL never wrap within a transfer.
REQ-024 sout SHALL be 0 and sout_en SHALL be 0 outside SHIFT.
REQ-025 RxData SHALL be driven from Q at all times; it is valid only while out_valid=1.

Reset
REQ-026 Resetn low SHALL set the state to IDLE, Q=0, counter=0, out_valid=0, sout=0 and sout_en=0; in_ready SHALL be 1 after release.
REQ-027 Reset asserted mid-SHIFT or mid-DONE SHALL discard the transfer immediately (asynchronously).

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, SHIFT, DONE) and the default width constant.
REQ-029 The shift register SHALL be a separate sub-module, shift_left_reg.
- Ports: parallel load, shift enable, serial-in to bit 0, Q out, and the same Clock/Resetn.
- The controller drives load and enable.

Verification
REQ-030 N=8, Data=8'hA5, sin=0, out_ready=1 -> sout over 8 cycles = 1,0,1,0,0,1,0,1; RxData=8'h00; out_valid for 1 cycle at cycle 9 after accept.
REQ-031 Loopback (sin tied to sout), Data=8'h3C -> RxData=8'h3C.
REQ-032 Data=8'hFF, out_ready held low 5 cycles in DONE -> out_valid and RxData stable for all 5 cycles; IDLE one cycle after out_ready rises.
REQ-033 abort on the 3rd SHIFT cycle -> IDLE next edge, no out_valid, in_ready=1.
REQ-034 in_valid pulsed with Data=8'h11 during SHIFT of 8'hA5 -> ignored; sout sequence is still that of 8'hA5.
REQ-035 Resetn low during the 4th SHIFT cycle -> outputs take reset values immediately; a following transfer of 8'h81 completes correctly.
